// File: rtl/soundrive_pkg.sv
// Shared widths, FSM state type and channel adder helper for the Soundrive mixer.
// Used by soundrive_mixer and soundrive_mul.
package soundrive_pkg;

   localparam int CH_W      = 8;
   localparam int SUM_W     = CH_W + 1;
   localparam int GAIN_W    = 4;
   localparam int OUT_W_DEF = SUM_W + GAIN_W;
   localparam int STEP_W    = $clog2(GAIN_W);

   typedef enum logic [2:0] {
      IDLE,
      ADD_L,
      ADD_R,
      MUL_L,
      MUL_R,
      DONE
   } state_t;

   // Widen before adding so the carry out of two full-scale channels survives.
   function automatic logic [SUM_W-1:0] add_ch(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
      return SUM_W'(a) + SUM_W'(b);
   endfunction

endpackage

// File: rtl/soundrive_mul.sv
// Sequential 9x4 shift-add multiplier: one gain bit per ce-cycle, LSB first,
// four ce-cycles from start to a complete product. done marks the final step.
module soundrive_mul
   import soundrive_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 start,
   input  logic [SUM_W-1:0]     a,
   input  logic [GAIN_W-1:0]    b,
   output logic [OUT_W_DEF-1:0] product,
   output logic                 busy,
   output logic                 done
);

   logic [OUT_W_DEF-1:0] mcand;
   logic [GAIN_W-2:0]    mplier;
   logic [STEP_W-1:0]    step;

   assign done = busy && (step == STEP_W'(GAIN_W - 1));

   // NOTE: registered state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         step    <= '0;
         busy    <= 1'b0;
      end else if (ce) begin
         if (!busy && start) begin
            // First step consumes gain bit 0 directly from the input.
            product <= b[0] ? OUT_W_DEF'(a) : '0;
            mcand   <= OUT_W_DEF'(a) << 1;
            mplier  <= b[GAIN_W-1:1];
            step    <= STEP_W'(1);
            busy    <= 1'b1;
         end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            step    <= done ? '0 : step + STEP_W'(1);
            busy    <= !done;
         end
      end
   end

endmodule

// File: rtl/soundrive_mixer.sv
// Soundrive 4-channel mixer: snapshots the channel latches on tick, sums each side
// with one shared adder and, when SOUNDRIVE_VOLUME_EN is defined, scales by gain/16.
module soundrive_mixer
   import soundrive_pkg::*;
#(
   parameter int OUT_W = OUT_W_DEF
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   input  logic              tick,
   input  logic [CH_W-1:0]   l1,
   input  logic [CH_W-1:0]   l2,
   input  logic [CH_W-1:0]   r1,
   input  logic [CH_W-1:0]   r2,
   input  logic [GAIN_W-1:0] vol_l,
   input  logic [GAIN_W-1:0] vol_r,
   input  logic              ovr_clr,
   output logic [OUT_W-1:0]  left,
   output logic [OUT_W-1:0]  right,
   output logic              valid,
   output logic              busy,
   output logic              overrun
);

   state_t           state;
   logic [CH_W-1:0]  s_l1, s_l2, s_r1, s_r2;
   logic [SUM_W-1:0] sum_l, sum_r;
   logic [CH_W-1:0]  add_a, add_b;
   logic [SUM_W-1:0] add_sum;

   // One adder serves both sides; the state picks which snapshot pair feeds it.
   assign add_a   = (state == ADD_L) ? s_l1 : s_r1;
   assign add_b   = (state == ADD_L) ? s_l2 : s_r2;
   assign add_sum = add_ch(add_a, add_b);
   assign busy    = (state != IDLE);

`ifdef SOUNDRIVE_VOLUME_EN
   logic [GAIN_W-1:0]    s_vol_l, s_vol_r;
   logic [OUT_W_DEF-1:0] prod_l, mul_product;
   logic                 mul_start, mul_busy, mul_done, mul_right;

   assign mul_right = (state == MUL_R);
   assign mul_start = ((state == MUL_L) || mul_right) && !mul_busy;

   soundrive_mul u_mul (
      .clock   (clock),
      .reset   (reset),
      .ce      (ce),
      .start   (mul_start),
      .a       (mul_right ? sum_r : sum_l),
      .b       (mul_right ? s_vol_r : s_vol_l),
      .product (mul_product),
      .busy    (mul_busy),
      .done    (mul_done)
   );
`else
   logic unused_vol;
   assign unused_vol = ^{vol_l, vol_r};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         s_l1    <= '0;
         s_l2    <= '0;
         s_r1    <= '0;
         s_r2    <= '0;
         sum_l   <= '0;
         sum_r   <= '0;
         left    <= '0;
         right   <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
`ifdef SOUNDRIVE_VOLUME_EN
         s_vol_l <= '0;
         s_vol_r <= '0;
         prod_l  <= '0;
`endif
      end else begin
         valid <= 1'b0;
         if (ovr_clr)
            overrun <= 1'b0;
         // Placed after the clear so a same-clock set takes priority.
         if (ce && tick && (state != IDLE))
            overrun <= 1'b1;

         if (ce) begin
            case (state)
               IDLE: begin
                  if (tick) begin
                     s_l1  <= l1;
                     s_l2  <= l2;
                     s_r1  <= r1;
                     s_r2  <= r2;
`ifdef SOUNDRIVE_VOLUME_EN
                     s_vol_l <= vol_l;
                     s_vol_r <= vol_r;
`endif
                     state <= ADD_L;
                  end
               end
               ADD_L: begin
                  sum_l <= add_sum;
                  state <= ADD_R;
               end
               ADD_R: begin
                  sum_r <= add_sum;
`ifdef SOUNDRIVE_VOLUME_EN
                  state <= MUL_L;
`else
                  state <= DONE;
`endif
               end
`ifdef SOUNDRIVE_VOLUME_EN
               MUL_L: begin
                  if (mul_done)
                     state <= MUL_R;
               end
               MUL_R: begin
                  // The left product is still in the multiplier on the first MUL_R cycle.
                  if (mul_start)
                     prod_l <= mul_product;
                  if (mul_done)
                     state <= DONE;
               end
               DONE: begin
                  left  <= prod_l;
                  right <= mul_product;
                  valid <= 1'b1;
                  state <= IDLE;
               end
`else
               DONE: begin
                  left  <= {sum_l, {GAIN_W{1'b0}}};
                  right <= {sum_r, {GAIN_W{1'b0}}};
                  valid <= 1'b1;
                  state <= IDLE;
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
